taxi_apb_master: RTL and testbench
==================================

# taxi_apb_master

Single-outstanding APB initiator. It converts a valid/ready command stream into APB SETUP/ACCESS transfers on a `taxi_apb_if` manager port and returns read data and error status on a valid/ready response stream. Local control logic (CSR sequencers, debug bridges) uses it to drive APB responders such as the APB RAMs and register blocks. It completes the APB pair alongside the existing responder-side blocks.

## Interface

Parameters:
- `TIMEOUT`, default 0: maximum ACCESS-phase cycles before abort; 0 disables the timeout.
- `DATA_W`, `ADDR_W` and `STRB_W` come from `m_apb`; `STRB_W*8 == DATA_W` is checked at elaboration.

Ports:
- `clk`  in  1  block clock; all logic is on the rising edge.
- `rst`  in  1  reset; **one clock; reset is asynchronous and active-high**.
- `cmd_addr`  in  ADDR_W  transfer address.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_wdata`  in  DATA_W  write data.
- `cmd_strb`  in  STRB_W  write byte strobes.
- `cmd_prot`  in  3  value driven on `pprot`.
- `cmd_valid` / `cmd_ready`  in / out  1  command handshake.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes.
- `rsp_err`  out  1  `pslverr` was sampled high, or the transfer timed out.
- `rsp_timeout`  out  1  the transfer was aborted by the timeout.
- `rsp_valid` / `rsp_ready`  out / in  1  response handshake.
- `busy`  out  1  high in every state except IDLE.
- `m_apb`  intf  -  `taxi_apb_if` manager modport.

## Operation

- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `cmd_ready` = 1. On `cmd_valid && cmd_ready`:
  - register addr, write, wdata, prot and strb;
  - strb is forced to 0 for reads;
  - go to SETUP.
- SETUP: `psel` = 1, `penable` = 0; always goes to ACCESS on the next cycle.
- ACCESS: `psel` = 1, `penable` = 1.
  - On `pready`: capture `prdata` (reads only, otherwise 0) and `pslverr`; drop `psel`/`penable`; go to RESP.
- Timeout (`TIMEOUT` > 0):
  - a counter clears on entry to ACCESS and increments each cycle `pready` is low;
  - when it reaches `TIMEOUT` with `pready` still low, the transfer aborts: `psel`/`penable` drop, `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0, go to RESP.
  - Counter width is `$clog2(TIMEOUT+1)`; it saturates and never wraps.
- RESP: `rsp_valid` = 1, with response fields held stable. On `rsp_ready`, go to IDLE.
- `paddr`, `pwrite`, `pwdata`, `pstrb` and `pprot` hold from SETUP through ACCESS and keep their last value afterwards.
- One transfer is outstanding at a time; `cmd_ready` is low in SETUP, ACCESS and RESP.

## Timing

- All outputs are registered.
- Reset values:
  - state IDLE;
  - `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `pprot` all 0;
  - `rsp_valid`, `rsp_err`, `rsp_timeout`, `rsp_rdata` all 0;
  - `busy` 0; `cmd_ready` 1 once reset deasserts.
- Command accepted at edge N:
  - `psel` rises after edge N;
  - `penable` rises after N+1;
  - if `pready` is high at N+2, `rsp_valid` rises after N+2.
- Minimum command-to-response latency is 3 cycles; minimum spacing between accepts is 4 cycles.
- Each wait state (`pready` low in ACCESS) adds one cycle.
- `pready` and `pslverr` are ignored outside ACCESS.
- Reset mid-transfer: `psel`/`penable` drop asynchronously, no response is produced, and any pending response is discarded.
- `rsp_ready` held high: RESP lasts exactly one cycle.

## Structure

- Shared package `taxi_apb_pkg`:
  - `pprot` bit constants: `APB_PROT_PRIV` = 3'b001, `APB_PROT_NONSEC` = 3'b010, `APB_PROT_INSTR` = 3'b100;
  - this block's FSM state enum.
- No sub-module; the timeout counter is inline.
- Test bench `test_taxi_apb_master` pairs `taxi_apb_master` with `taxi_apb_dp_ram` port A, with `ADDR_W` = 16 (RAM) and interface `ADDR_W` = 32.

## Test plan

- Write 0xDEADBEEF to 0x0010 with strb 0xF, then read 0x0010 -> `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0; 3-cycle latency when the responder has no wait states.
- Write 0x000000AA to 0x0010 with strb 0x1 over 0xDEADBEEF, then read -> 0xDEADBEAA; `pstrb` = 0 on the read.
- Stub responder with 3 wait states, then `pslverr` = 1 -> response after 6 cycles with `rsp_err` = 1, `rsp_timeout` = 0; `paddr`/`pwdata` stable through ACCESS.
- `TIMEOUT` = 16, responder never asserts `pready` -> abort after 16 ACCESS cycles: `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0, `psel` = 0 on the following cycle.
- `rsp_ready` held low for 10 cycles -> `rsp_valid` and data stay stable, `cmd_ready` = 0, no new `psel`.
- Assert `rst` during ACCESS -> `psel`, `penable` and `rsp_valid` are 0 immediately; after reset, the next command completes normally.

Source files
------------

// File: rtl/taxi_apb_pkg.sv
// Shared APB definitions: pprot bit constants and the initiator FSM state type.
package taxi_apb_pkg;

  localparam logic [2:0] APB_PROT_PRIV   = 3'b001;
  localparam logic [2:0] APB_PROT_NONSEC = 3'b010;
  localparam logic [2:0] APB_PROT_INSTR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_t;

endpackage

// File: rtl/taxi_apb_if.sv
// APB bus bundle with manager and responder views.
interface taxi_apb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STRB_W = DATA_W/8
) ();

  logic [ADDR_W-1:0] paddr;
  logic [2:0]        pprot;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport mst (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slv (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/taxi_apb_master.sv
// Single-outstanding APB initiator: valid/ready command in, APB transfer out,
// read data and error status back on a valid/ready response stream.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SETUP  | psel high, penable low, one cycle
// ACCESS | psel and penable high until pready or timeout
// RESP   | rsp_valid high until rsp_ready
module taxi_apb_master
  import taxi_apb_pkg::*;
#(
  parameter int TIMEOUT = 0,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int STRB_W  = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  input  logic [2:0]        cmd_prot,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              busy,
  taxi_apb_if.mst           m_apb
);

  if (STRB_W*8 != DATA_W) begin : g_strb_chk
    $error("taxi_apb_master: STRB_W*8 must equal DATA_W");
  end

  localparam bit TO_EN = TIMEOUT > 0;
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT+1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT-1 : 0);

  apb_mst_state_t state, state_next;

  logic              psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic [2:0]        pprot_q;
  logic              psel_d, penable_d, rsp_valid_d, busy_d, cmd_ready_d;
  logic [CNT_W-1:0]  to_cnt;
  logic              cmd_fire, to_hit;

  assign cmd_fire = cmd_valid && cmd_ready;
  // Abort on the edge that closes the TIMEOUT-th ACCESS cycle without pready.
  assign to_hit   = TO_EN && (state == ST_ACCESS) && !m_apb.pready && (to_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (cmd_fire) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (m_apb.pready || to_hit) state_next = ST_RESP;
      ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Handshake and bus strobes are decoded from the next state so they leave a register.
  always_comb begin
    psel_d      = (state_next == ST_SETUP) || (state_next == ST_ACCESS);
    penable_d   = (state_next == ST_ACCESS);
    rsp_valid_d = (state_next == ST_RESP);
    busy_d      = (state_next != ST_IDLE);
    cmd_ready_d = (state_next == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rsp_valid <= rsp_valid_d;
      busy      <= busy_d;
      cmd_ready <= cmd_ready_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      to_cnt      <= '0;
    end else begin
      if (cmd_fire) begin
        pwrite_q <= cmd_write;
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
        pstrb_q  <= cmd_write ? cmd_strb : '0;
        pprot_q  <= cmd_prot;
      end

      if (state == ST_ACCESS && m_apb.pready) begin
        rsp_rdata   <= pwrite_q ? '0 : m_apb.prdata;
        rsp_err     <= m_apb.pslverr;
        rsp_timeout <= 1'b0;
      end else if (to_hit) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end

      if (state == ST_SETUP)
        to_cnt <= '0;
      else if (TO_EN && state == ST_ACCESS && !m_apb.pready && to_cnt != CNT_MAX)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  assign m_apb.psel    = psel_q;
  assign m_apb.penable = penable_q;
  assign m_apb.pwrite  = pwrite_q;
  assign m_apb.paddr   = paddr_q;
  assign m_apb.pwdata  = pwdata_q;
  assign m_apb.pstrb   = pstrb_q;
  assign m_apb.pprot   = pprot_q;

endmodule

// File: tb/tb_taxi_apb_master.sv
// Bench for taxi_apb_master: behavioural APB RAM responder plus a shadow-memory model.
module tb_taxi_apb_master;
  import taxi_apb_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  int wait_cfg = 0;
  bit err_cfg  = 1'b0;
  bit hang_cfg = 1'b0;
  int wcnt = 0;

  bit [31:0] mem    [256];
  bit [31:0] shadow [256];

  always #5 clk = ~clk;

  taxi_apb_if #(.DATA_W(32), .ADDR_W(32)) apb ();

  taxi_apb_master #(.TIMEOUT(TO), .DATA_W(32), .ADDR_W(32), .STRB_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .cmd_strb(cmd_strb), .cmd_prot(cmd_prot), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .busy(busy),
    .m_apb(apb)
  );

  // Responder: RAM with programmable wait states; pslverr is driven even outside ACCESS
  always_comb begin
    apb.pready  = apb.psel && apb.penable && !hang_cfg && (wcnt >= wait_cfg);
    apb.prdata  = mem[apb.paddr[9:2]];
    apb.pslverr = err_cfg;
  end

  always @(posedge clk) begin
    if (apb.psel && apb.penable && !apb.pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (apb.psel && apb.penable && apb.pready && apb.pwrite)
      for (int b = 0; b < 4; b++)
        if (apb.pstrb[b]) mem[apb.paddr[9:2]][8*b +: 8] <= apb.pwdata[8*b +: 8];
  end

  wire [2:0] prot_unused = apb.pprot & (APB_PROT_PRIV | APB_PROT_NONSEC | APB_PROT_INSTR);

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] st);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Drives one command, follows it to the response and returns what was seen.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr,
                         output logic [31:0] rd, output logic er, output logic tmo,
                         output int lat, output bit bus_ok);
    int guard;
    logic [3:0] exp_strb;
    exp_strb = wr ? st : 4'h0;
    bus_ok = 1'b1;
    @(negedge clk);
    cmd_addr = addr; cmd_write = wr; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
    cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (apb.psel !== 1'b1 || apb.penable !== (lat > 1) || busy !== 1'b1 || cmd_ready !== 1'b0)
        bus_ok = 1'b0;
      if (apb.paddr !== addr || apb.pwrite !== wr || apb.pwdata !== wd ||
          apb.pstrb !== exp_strb || apb.pprot !== pr)
        bus_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid || apb.psel !== 1'b0 || apb.penable !== 1'b0) bus_ok = 1'b0;
    rd = rsp_rdata; er = rsp_err; tmo = rsp_timeout;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) bus_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    total++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, apb.pstrb, apb.pprot} !== '0) begin
      bad++; $display("FAIL reset_bus got psel=%b pen=%b paddr=%h want all 0", apb.psel, apb.penable, apb.paddr);
    end
    total++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, busy} !== '0) begin
      bad++; $display("FAIL reset_rsp got valid=%b err=%b busy=%b want 0", rsp_valid, rsp_err, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_ready got ready=%b busy=%b want 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic;
    logic [31:0] rd; logic er, tmo; int lat; bit ok;
    do_xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, APB_PROT_PRIV, rd, er, tmo, lat, ok);
    shadow[4] = merge(shadow[4], 32'hDEADBEEF, 4'hF);
    total++;
    if (lat !== 3 || er !== 1'b0 || !ok || rd !== 32'h0) begin
      bad++; $display("FAIL basic_write got lat=%0d err=%b bus=%b rd=%h want 3/0/1/0", lat, er, ok, rd);
    end
    do_xfer(32'h10, 1'b0, 32'h0, 4'h0, APB_PROT_NONSEC, rd, er, tmo, lat, ok);
    total++;
    if (rd !== shadow[4]) begin bad++; $display("FAIL basic_read got %h want %h", rd, shadow[4]); end
    total++;
    if (lat !== 3 || er !== 1'b0 || tmo !== 1'b0 || !ok) begin
      bad++; $display("FAIL basic_read_lat got lat=%0d err=%b bus=%b want 3/0/1", lat, er, ok);
    end
  endtask

  task automatic test_strb;
    logic [31:0] rd; logic er, tmo; int lat; bit ok;
    do_xfer(32'h10, 1'b1, 32'h000000AA, 4'h1, 3'b000, rd, er, tmo, lat, ok);
    shadow[4] = merge(shadow[4], 32'h000000AA, 4'h1);
    total++;
    if (!ok || er !== 1'b0) begin bad++; $display("FAIL strb_write got bus=%b err=%b want 1/0", ok, er); end
    // A read still presents strb 0xF on the command side; the bus must show 0
    do_xfer(32'h10, 1'b0, 32'h12345678, 4'hF, 3'b000, rd, er, tmo, lat, ok);
    total++;
    if (rd !== 32'hDEADBEAA) begin bad++; $display("FAIL strb_read got %h want %h", rd, 32'hDEADBEAA); end
    total++;
    if (!ok) begin bad++; $display("FAIL strb_read_bus got bus=%b want 1", ok); end
  endtask

  task automatic test_wait_err;
    logic [31:0] rd; logic er, tmo; int lat; bit ok;
    @(negedge clk); wait_cfg = 3; err_cfg = 1'b1;
    do_xfer(32'h10, 1'b0, 32'hCAFEF00D, 4'h0, APB_PROT_INSTR, rd, er, tmo, lat, ok);
    @(negedge clk); wait_cfg = 0; err_cfg = 1'b0;
    total++;
    if (lat !== 6) begin bad++; $display("FAIL wait_lat got %0d want 6", lat); end
    total++;
    if (er !== 1'b1 || tmo !== 1'b0) begin bad++; $display("FAIL wait_err got err=%b tmo=%b want 1/0", er, tmo); end
    total++;
    if (!ok || rd !== shadow[4]) begin bad++; $display("FAIL wait_bus got bus=%b rd=%h want 1/%h", ok, rd, shadow[4]); end
  endtask

  task automatic test_timeout;
    logic [31:0] rd; logic er, tmo; int lat; bit ok;
    @(negedge clk); hang_cfg = 1'b1;
    do_xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b111, rd, er, tmo, lat, ok);
    @(negedge clk); hang_cfg = 1'b0;
    total++;
    if (lat !== 2 + TO) begin bad++; $display("FAIL timeout_lat got %0d want %0d", lat, 2 + TO); end
    total++;
    if (er !== 1'b1 || tmo !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL timeout_rsp got err=%b tmo=%b rd=%h want 1/1/0", er, tmo, rd);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL timeout_bus got bus=%b want 1", ok); end
  endtask

  task automatic test_hold;
    int guard;
    bit steady;
    @(negedge clk);
    cmd_addr = 32'h10; cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_addr = 32'h20; cmd_write = 1'b1;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    steady = rsp_valid;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== shadow[4] || cmd_ready !== 1'b0 || apb.psel !== 1'b0)
        steady = 1'b0;
      @(posedge clk); #1;
    end
    total++;
    if (!steady) begin bad++; $display("FAIL hold_stable got valid=%b rd=%h ready=%b psel=%b", rsp_valid, rsp_rdata, cmd_ready, apb.psel); end
    @(negedge clk); cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || apb.psel !== 1'b0) begin
      bad++; $display("FAIL hold_release got valid=%b psel=%b want 0/0", rsp_valid, apb.psel);
    end
  endtask

  task automatic test_reset_mid;
    int guard;
    logic [31:0] rd; logic er, tmo; int lat; bit ok;
    @(negedge clk); hang_cfg = 1'b1;
    cmd_addr = 32'h10; cmd_write = 1'b1; cmd_wdata = 32'h55555555; cmd_strb = 4'hF; cmd_prot = '0;
    cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    guard = 0;
    while (!apb.penable && guard < 10) begin @(posedge clk); #1; guard++; end
    @(negedge clk); rst = 1'b1; #1;
    total++;
    if (apb.psel !== 1'b0 || apb.penable !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_access got psel=%b pen=%b valid=%b want 0", apb.psel, apb.penable, rsp_valid);
    end
    hang_cfg = 1'b0;
    @(negedge clk); rst = 1'b0;
    // Pending response must also vanish under reset
    @(negedge clk);
    cmd_write = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 10) begin @(posedge clk); #1; guard++; end
    @(negedge clk); rst = 1'b1; #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_resp got valid=%b busy=%b want 0/0", rsp_valid, busy);
    end
    @(negedge clk); rst = 1'b0;
    do_xfer(32'h10, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, tmo, lat, ok);
    total++;
    if (rd !== shadow[4] || lat !== 3 || er !== 1'b0 || !ok) begin
      bad++; $display("FAIL rst_recover got rd=%h lat=%0d err=%b want %h/3/0", rd, lat, er, shadow[4]);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, wd, addr, exp_rd; logic er, tmo, wr; logic [3:0] st; int lat, idx, w; bit ok, e;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 15);
      addr = 32'(idx * 4);
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      w = $urandom_range(0, 3);
      e = ($urandom_range(0, 3) == 0);
      @(negedge clk); wait_cfg = w; err_cfg = e;
      exp_rd = wr ? 32'h0 : shadow[idx];
      do_xfer(addr, wr, wd, st, 3'($urandom_range(0, 7)), rd, er, tmo, lat, ok);
      if (wr) shadow[idx] = merge(shadow[idx], wd, st);
      total++;
      if (rd !== exp_rd || er !== e || tmo !== 1'b0) begin
        bad++; $display("FAIL rand_rsp n=%0d got rd=%h err=%b tmo=%b want %h/%b/0", n, rd, er, tmo, exp_rd, e);
      end
      total++;
      if (lat !== 3 + w || !ok) begin
        bad++; $display("FAIL rand_timing n=%0d got lat=%0d bus=%b want %0d/1", n, lat, ok, 3 + w);
      end
    end
    @(negedge clk); wait_cfg = 0; err_cfg = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    test_reset;
    test_basic;
    test_strb;
    test_wait_err;
    test_timeout;
    test_hold;
    test_reset_mid;
    test_random;
    if (prot_unused === 3'bxxx) $display("note: pprot unknown");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
